// File: rtl/dsp_mult_acc.sv
// dsp_mult_acc: frame accumulator for dsp_mult products.
// Sums beats until in_last, then holds the result on a valid/ready output.
module dsp_mult_acc #(
  parameter int PROD_W = 38,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_z,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   osum_q, osum_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic               oovf_q, oovf_d;
  logic [ACC_W:0]     sum_w;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_nxt;

  assign in_ready  = (state_q != S_HOLD) && !clr;
  assign out_valid = (state_q == S_HOLD);
  assign out_sum   = osum_q;
  assign out_count = ocnt_q;
  assign out_ovf   = oovf_q;

  // Next-state and datapath: clr first, then beat accept or output drain.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    osum_d  = osum_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    sum_w   = {1'b0, acc_q} + (ACC_W+1)'(in_z);
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_nxt = ovf_q | sum_w[ACC_W];
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: begin
          if (in_valid) begin
            if (in_last) begin
              state_d = S_HOLD;
              osum_d  = sum_w[ACC_W-1:0];
              ocnt_d  = cnt_inc;
              oovf_d  = ovf_nxt;
              acc_d   = '0;
              cnt_d   = '0;
              ovf_d   = 1'b0;
            end else begin
              state_d = S_ACC;
              acc_d   = sum_w[ACC_W-1:0];
              cnt_d   = cnt_inc;
              ovf_d   = ovf_nxt;
            end
          end
        end
      endcase
    end
  end

  // State and result registers with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      osum_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      osum_q  <= osum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule

// File: tb/tb_dsp_mult_acc.sv
// tb_dsp_mult_acc: directed and random MAC frames into dsp_mult_acc.
// Runs a 48-bit and a 38-bit accumulator side by side.
module tb_dsp_mult_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [37:0] in_z;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, in_ready38;
  logic        out_valid, out_valid38;
  logic [47:0] out_sum;
  logic [37:0] out_sum38;
  logic [15:0] out_count, out_count38;
  logic        out_ovf, out_ovf38;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] s48;
    logic [63:0] s38;
    logic [63:0] cnt;
    logic        o48;
    logic        o38;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_sum;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  dsp_mult_acc #(.PROD_W(38), .ACC_W(48), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_z(in_z), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  dsp_mult_acc #(.PROD_W(38), .ACC_W(38), .CNT_W(16)) dut38 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready38),
    .in_z(in_z), .in_last(in_last),
    .out_valid(out_valid38), .out_ready(out_ready),
    .out_sum(out_sum38), .out_count(out_count38), .out_ovf(out_ovf38)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each result on the cycle its handshake completes.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready && !clr) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'(out_sum), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("sum48", 64'(out_sum), e.s48);
        chk("cnt48", 64'(out_count), e.cnt);
        chk("ovf48", 64'(out_ovf), 64'(e.o48));
        chk("valid38", 64'(out_valid38), 64'd1);
        chk("sum38", 64'(out_sum38), e.s38);
        chk("cnt38", 64'(out_count38), e.cnt);
        chk("ovf38", 64'(out_ovf38), 64'(e.o38));
      end
    end
  end

  task automatic model_reset();
    m_sum = '0;
    m_cnt = '0;
  endtask

  task automatic send(input logic [37:0] z, input logic last);
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_z     = z;
    in_last  = last;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed in_ready=0 expected 1");
    end
    m_sum = m_sum + 64'(z);
    m_cnt = m_cnt + 64'd1;
    if (last) begin
      e.s48 = m_sum & 64'hFFFF_FFFF_FFFF;
      e.s38 = m_sum & 64'h3F_FFFF_FFFF;
      e.cnt = (m_cnt > 64'd65535) ? 64'd65535 : m_cnt;
      e.o48 = (m_sum >> 48) != 0;
      e.o38 = (m_sum >> 38) != 0;
      sb.push_back(e);
      model_reset();
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [19:0] a;
    logic [17:0] b;
    int n;
    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    in_z = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // 3-beat frame, consumer always ready
    @(negedge clk);
    out_ready = 1'b1;
    send(38'd10, 1'b0);
    send(38'd20, 1'b0);
    send(38'd30, 1'b1);
    #1;
    chk("f3_valid", 64'(out_valid), 64'd1);
    chk("f3_in_ready_hold", 64'(in_ready), 64'd0);
    chk("f3_sum", 64'(out_sum), 64'd60);
    @(negedge clk);
    #1;
    chk("f3_valid_drop", 64'(out_valid), 64'd0);
    chk("f3_in_ready_after", 64'(in_ready), 64'd1);

    // single-beat frame of maximum product
    send(38'h3F_FFFF_FFFF, 1'b1);
    // two max beats: wraps the 38-bit accumulator
    send(38'h3F_FFFF_FFFF, 1'b0);
    send(38'h3F_FFFF_FFFF, 1'b1);
    #1;
    chk("ovf38_sum", 64'(out_sum38), 64'h3F_FFFF_FFFE);
    chk("ovf38_flag", 64'(out_ovf38), 64'd1);
    send(38'd5, 1'b1);
    #1;
    chk("post_ovf_flag", 64'(out_ovf38), 64'd0);
    chk("post_ovf_sum", 64'(out_sum38), 64'd5);

    // backpressure on a {7,8} frame
    @(negedge clk);
    out_ready = 1'b0;
    send(38'd7, 1'b0);
    send(38'd8, 1'b1);
    in_valid = 1'b1;
    in_z = 38'd99;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(out_sum), 64'd15);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_gap_valid", 64'(out_valid), 64'd0);
    chk("bp_gap_in_ready", 64'(in_ready), 64'd1);
    send(38'd99, 1'b1);

    // clear mid-frame
    send(38'd100, 1'b0);
    send(38'd200, 1'b0);
    clr = 1'b1;
    in_valid = 1'b1;
    in_z = 38'd50;
    in_last = 1'b0;
    #1;
    chk("clr_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk("clr_valid", 64'(out_valid), 64'd0);
    send(38'd1, 1'b0);
    send(38'd2, 1'b1);
    #1;
    chk("clr_sum", 64'(out_sum), 64'd3);
    chk("clr_count", 64'(out_count), 64'd2);

    // random MAC: 50 frames of 16 A*B products
    for (int f = 0; f < 50; f++) begin
      for (int k = 0; k < 16; k++) begin
        a = 20'($urandom_range(20'hFFFFF, 0));
        b = 18'($urandom_range(18'h3FFFF, 0));
        send(38'(64'(a) * 64'(b)), k == 15);
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
